uart_frame_assembler: RTL and testbench

UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

---
 rtl/uart_frame_assembler.sv | 202 ++++++++++++++++++++
 tb/tb_uart_frame_assembler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_assembler.sv
// ---------------------------------------------------------------------------------------------
// uart_frame_assembler
//
// Collects bytes from a UART receiver into fixed-length frames of the form
//   SYNC_BYTE, payload[0] .. payload[NUM_BYTES-1], checksum
// where checksum is the XOR of all payload bytes. A frame whose checksum matches is
// presented on frame_data/frame_valid and held until the downstream handshake.
//
// Parameters
//   NUM_BYTES      payload bytes per frame (1..16)
//   SYNC_BYTE      frame start marker
//   TIMEOUT_CYCLES maximum idle cycles between bytes inside a frame (2..65535)
//
// Ports
//   clk          clock, all state changes on the rising edge
//   reset        synchronous active-low reset
//   rx_data      received byte, qualified by rx_enable
//   rx_enable    one-cycle strobe for rx_data
//   frame_data   assembled payload, first received byte in bits [7:0]
//   frame_valid  frame_data holds a checked frame
//   frame_ready  downstream accepts the frame when frame_valid is also high
//   chk_err      one-cycle pulse: checksum mismatch
//   timeout_err  one-cycle pulse: inter-byte timeout inside a frame
//   overrun      one-cycle pulse: byte dropped while a frame was held
//   busy         high whenever the assembler is not idle
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------------------------
module uart_frame_assembler #(
    parameter int unsigned NUM_BYTES      = 4,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_enable,
    output logic [8*NUM_BYTES-1:0] frame_data,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   chk_err,
    output logic                   timeout_err,
    output logic                   overrun,
    output logic                   busy
);

    // Byte index needs at least one bit even for single-byte frames.
    localparam int unsigned IdxW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_BYTES - 1);
    // Timeout fires on the edge at which the idle count would reach TIMEOUT_CYCLES.
    localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StCheck,
        StHold
    } state_e;

    state_e                 state_q, state_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [7:0]             csum_q, csum_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [8*NUM_BYTES-1:0] payload_q, payload_d;
    logic [8*NUM_BYTES-1:0] frame_data_q, frame_data_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   chk_err_q, chk_err_d;
    logic                   timeout_err_q, timeout_err_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q, busy_d;

    logic                   expiry;
    logic [15:0]            cnt_inc;

    // Saturating increment; the counter never wraps back to zero.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign expiry  = (cnt_q == CntLast);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        csum_d        = csum_q;
        cnt_d         = cnt_q;
        payload_d     = payload_q;
        frame_data_d  = frame_data_q;
        chk_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        overrun_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (rx_enable && (rx_data == SYNC_BYTE)) begin
                    state_d = StPayload;
                    idx_d   = '0;
                    csum_d  = '0;
                end
            end

            StPayload: begin
                // A strobe on the expiry edge wins over the timeout.
                if (rx_enable) begin
                    for (int unsigned b = 0; b < NUM_BYTES; b++) begin
                        if (idx_q == IdxW'(b)) begin
                            payload_d[8*b +: 8] = rx_data;
                        end
                    end
                    csum_d = csum_q ^ rx_data;
                    cnt_d  = '0;
                    if (idx_q == LastIdx) begin
                        state_d = StCheck;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (expiry) begin
                    state_d       = StIdle;
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StCheck: begin
                if (rx_enable) begin
                    cnt_d = '0;
                    if (rx_data == csum_q) begin
                        state_d      = StHold;
                        frame_data_d = payload_q;
                    end else begin
                        // Previously presented frame_data is deliberately kept.
                        state_d   = StIdle;
                        chk_err_d = 1'b1;
                    end
                end else if (expiry) begin
                    state_d       = StIdle;
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            StHold: begin
                cnt_d = '0;
                // Bytes are dropped here, even on the handshake edge, and never resync.
                if (rx_enable) begin
                    overrun_d = 1'b1;
                end
                if (frame_valid_q && frame_ready) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Registered status tracks the state being entered.
        frame_valid_d = (state_d == StHold);
        busy_d        = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            csum_q        <= '0;
            cnt_q         <= '0;
            payload_q     <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            csum_q        <= csum_d;
            cnt_q         <= cnt_d;
            payload_q     <= payload_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            chk_err_q     <= chk_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign chk_err     = chk_err_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// ---------------------------------------------------------------------------------------------
// Testbench for uart_frame_assembler: directed frame scenarios followed by randomized traffic,
// every cycle compared against a byte-queue reference model of the framing rules.
// ---------------------------------------------------------------------------------------------
module tb_uart_frame_assembler;

    localparam int unsigned NB   = 4;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam int unsigned TMO  = 1000;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      rx_data;
    logic            rx_enable;
    logic [8*NB-1:0] frame_data;
    logic            frame_valid;
    logic            frame_ready;
    logic            chk_err;
    logic            timeout_err;
    logic            overrun;
    logic            busy;

    always #5 clk = ~clk;

    uart_frame_assembler #(
        .NUM_BYTES      (NB),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_enable   (rx_enable),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .chk_err     (chk_err),
        .timeout_err (timeout_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            if (n_bad <= 40) begin
                $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
            end
        end
    endtask

    // Reference model: a frame is "open" after a sync byte and gathers bytes in a queue;
    // the byte after NB payload bytes is the checksum. A good frame is held until taken.
    bit              m_open;
    bit              m_held;
    logic [7:0]      m_bytes[$];
    int unsigned     m_idle;
    logic [8*NB-1:0] e_data;
    bit              e_valid, e_chk, e_tmo, e_ovr, e_busy;

    task automatic model_edge(input logic r, input logic en, input logic [7:0] d,
                              input logic rdy);
        logic [7:0] x;
        e_chk = 0;
        e_tmo = 0;
        e_ovr = 0;
        if (!r) begin
            m_open = 0;
            m_held = 0;
            m_bytes.delete();
            m_idle = 0;
            e_data = '0;
        end else if (m_held) begin
            if (en) e_ovr = 1;
            if (e_valid && rdy) m_held = 0;
        end else if (m_open) begin
            if (en) begin
                m_idle = 0;
                if (m_bytes.size() < NB) begin
                    m_bytes.push_back(d);
                end else begin
                    x = 8'h00;
                    foreach (m_bytes[i]) x ^= m_bytes[i];
                    if (x == d) begin
                        for (int i = 0; i < NB; i++) e_data[8*i +: 8] = m_bytes[i];
                        m_held = 1;
                    end else begin
                        e_chk = 1;
                    end
                    m_open = 0;
                    m_bytes.delete();
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    e_tmo  = 1;
                    m_open = 0;
                    m_bytes.delete();
                end
            end
        end else if (en && d == SYNC) begin
            m_open = 1;
            m_idle = 0;
            m_bytes.delete();
        end
        e_valid = m_held;
        e_busy  = m_open || m_held;
    endtask

    // Event counters for the directed scenario checks.
    int unsigned valid_hi, chk_cnt, tmo_cnt, ovr_cnt;

    task automatic clr_counts();
        valid_hi = 0;
        chk_cnt  = 0;
        tmo_cnt  = 0;
        ovr_cnt  = 0;
    endtask

    task automatic step(input logic r, input logic en, input logic [7:0] d, input logic rdy);
        reset       = r;
        rx_enable   = en;
        rx_data     = d;
        frame_ready = rdy;
        @(posedge clk);
        model_edge(r, en, d, rdy);
        #1;
        check("frame_data", frame_data, e_data);
        check("frame_valid", frame_valid, e_valid);
        check("chk_err", chk_err, e_chk);
        check("timeout_err", timeout_err, e_tmo);
        check("overrun", overrun, e_ovr);
        check("busy", busy, e_busy);
        if (frame_valid) valid_hi++;
        if (chk_err) chk_cnt++;
        if (timeout_err) tmo_cnt++;
        if (overrun) ovr_cnt++;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b[$], input logic rdy);
        foreach (b[i]) step(1'b1, 1'b1, b[i], rdy);
    endtask

    task automatic idle(input int unsigned n, input logic rdy);
        repeat (n) step(1'b1, 1'b0, 8'h00, rdy);
    endtask

    logic [7:0]  fr[$];
    logic [7:0]  xb, rb;
    int unsigned gap;

    initial begin
        reset       = 1'b0;
        rx_enable   = 1'b0;
        rx_data     = 8'h00;
        frame_ready = 1'b0;
        m_open = 0; m_held = 0; m_idle = 0; e_data = '0;
        e_valid = 0; e_chk = 0; e_tmo = 0; e_ovr = 0; e_busy = 0;
        clr_counts();
        @(negedge clk);

        // Reset state, with a strobe that must be ignored.
        step(1'b0, 1'b1, SYNC, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("reset_busy", busy, 1'b0);

        // Good frame taken immediately.
        clr_counts();
        send('{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}, 1'b1);
        idle(3, 1'b1);
        check("good_data", frame_data, 32'h44332211);
        check("good_valid_len", valid_hi, 1);
        check("good_errs", chk_cnt + tmo_cnt + ovr_cnt, 0);

        // Bad checksum leaves previous frame_data in place.
        clr_counts();
        send('{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00}, 1'b1);
        idle(3, 1'b1);
        check("bad_chk_cnt", chk_cnt, 1);
        check("bad_valid", valid_hi, 0);
        check("bad_busy", busy, 1'b0);
        check("bad_data_kept", frame_data, 32'h44332211);

        // Inter-byte timeout, then a clean frame.
        clr_counts();
        send('{8'hA5, 8'h01, 8'h02}, 1'b1);
        idle(TMO - 1, 1'b1);
        check("tmo_not_yet", tmo_cnt, 0);
        idle(1, 1'b1);
        check("tmo_pulse", timeout_err, 1'b1);
        idle(2, 1'b1);
        check("tmo_cnt", tmo_cnt, 1);
        check("tmo_busy", busy, 1'b0);
        send('{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40}, 1'b1);
        idle(2, 1'b1);
        check("after_tmo_data", frame_data, 32'h40302010);

        // Strobe on the expiry edge is accepted.
        clr_counts();
        send('{8'hA5, 8'h05}, 1'b1);
        idle(TMO - 1, 1'b1);
        send('{8'h02, 8'h03, 8'h04, 8'h00}, 1'b1);
        idle(2, 1'b1);
        check("expiry_edge_tmo", tmo_cnt, 0);
        check("expiry_edge_data", frame_data, 32'h04030205);

        // Held frame with overruns, then handshake.
        clr_counts();
        send('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04}, 1'b0);
        for (int c = 0; c < 20; c++) begin
            if (c == 5) step(1'b1, 1'b1, 8'h55, 1'b0);
            else if (c == 12) step(1'b1, 1'b1, 8'h66, 1'b0);
            else step(1'b1, 1'b0, 8'h00, 1'b0);
        end
        check("hold_ovr_cnt", ovr_cnt, 2);
        check("hold_valid", frame_valid, 1'b1);
        check("hold_data", frame_data, 32'h04030201);
        step(1'b1, 1'b1, SYNC, 1'b1);  // handshake with a same-edge byte
        check("hs_ovr", overrun, 1'b1);
        check("hs_valid", frame_valid, 1'b0);
        check("hs_busy", busy, 1'b0);

        // Reset mid-frame, then a fresh frame.
        send('{8'hA5, 8'hAA, 8'hBB, 8'hCC}, 1'b1);
        step(1'b0, 1'b1, 8'hDD, 1'b1);
        check("midrst_data", frame_data, 32'h0);
        check("midrst_busy", busy, 1'b0);
        step(1'b0, 1'b1, SYNC, 1'b1);
        send('{8'hA5, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00}, 1'b1);
        idle(2, 1'b1);
        check("midrst_new_data", frame_data, 32'hDDCCBBAA);

        // Junk before sync; sync value inside payload.
        clr_counts();
        send('{8'h00, 8'hFF, 8'h12, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00}, 1'b0);
        check("junk_valid", frame_valid, 1'b1);
        check("junk_data", frame_data, 32'hA5A5A5A5);
        step(1'b1, 1'b0, 8'h00, 1'b1);

        // Randomized frames: bad checksums, junk, random ready, rare long gaps and resets.
        for (int f = 0; f < 250; f++) begin
            fr.delete();
            if ($urandom_range(0, 7) == 0) fr.push_back(8'($urandom));
            fr.push_back(($urandom_range(0, 9) == 0) ? 8'($urandom) : SYNC);
            xb = 8'h00;
            for (int i = 0; i < NB; i++) begin
                rb = ($urandom_range(0, 5) == 0) ? SYNC : 8'($urandom);
                fr.push_back(rb);
                xb ^= rb;
            end
            fr.push_back(($urandom_range(0, 3) == 0) ? (xb ^ 8'($urandom_range(1, 255))) : xb);
            foreach (fr[i]) begin
                if ($urandom_range(0, 299) == 0) gap = $urandom_range(TMO - 2, TMO + 1);
                else gap = $urandom_range(0, 3);
                repeat (gap) step(1'b1, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 199) == 0) step(1'b0, 1'($urandom), SYNC, 1'b1);
                step(1'b1, 1'b1, fr[i], 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
